// File: rtl/regfile_param.sv
// Parameterized two-read/one-write register file with busy (scoreboard) bits
// and a post-reset CLEAR sequence that zeroes every entry one per cycle.
module regfile_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [AW-1:0]    WriteAddress,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Reserve,
  input  logic [AW-1:0]    ReserveAddr,
  input  logic [AW-1:0]    ReadAddrA,
  input  logic [AW-1:0]    ReadAddrB,
  output logic [WIDTH-1:0] DataOutputA,
  output logic [WIDTH-1:0] DataOutputB,
  output logic             BusyA,
  output logic             BusyB,
  output logic             Ready,
  output logic             WriteDropped
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              dropped_q, dropped_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic              run_s;
  logic              wr_en_s;
  logic              res_en_s;
  logic              zero_a_s;
  logic              zero_b_s;
  logic              hit_a_s;
  logic              hit_b_s;

  assign run_s    = (state_q == ST_RUN);
  assign zero_a_s = ZERO_REG && (ReadAddrA == {AW{1'b0}});
  assign zero_b_s = ZERO_REG && (ReadAddrB == {AW{1'b0}});
  // Address 0 is hardwired under ZERO_REG, so its writes/reserves vanish silently.
  assign wr_en_s  = run_s && write &&
                    !(ZERO_REG && (WriteAddress == {AW{1'b0}}));
  assign res_en_s = run_s && Reserve &&
                    !(ZERO_REG && (ReserveAddr == {AW{1'b0}}));
  assign hit_a_s  = BYPASS && wr_en_s && (ReadAddrA == WriteAddress);
  assign hit_b_s  = BYPASS && wr_en_s && (ReadAddrB == WriteAddress);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    dropped_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        dropped_d = write | Reserve;
        if (clr_ptr_q == {AW{1'b1}}) begin
          state_d   = ST_RUN;
          clr_ptr_d = {AW{1'b0}};
        end else begin
          clr_ptr_d = clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = {AW{1'b0}};
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= {AW{1'b0}};
      ready_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage is deliberately not reset; CLEAR zeroes it. Reserve is applied
  // after the write so that a same-cycle write+reserve leaves busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= busy_q;
    end else if (state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q]  <= {WIDTH{1'b0}};
      busy_q[clr_ptr_q] <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[WriteAddress]  <= WriteData;
        busy_q[WriteAddress] <= 1'b0;
      end
      if (res_en_s) begin
        busy_q[ReserveAddr] <= 1'b1;
      end
    end
  end

  always_comb begin
    DataOutputA = {WIDTH{1'b0}};
    BusyA       = 1'b0;
    if (run_s && !zero_a_s) begin
      DataOutputA = hit_a_s ? WriteData : mem_q[ReadAddrA];
      BusyA       = busy_q[ReadAddrA];
    end else begin
      DataOutputA = {WIDTH{1'b0}};
      BusyA       = 1'b0;
    end
  end

  always_comb begin
    DataOutputB = {WIDTH{1'b0}};
    BusyB       = 1'b0;
    if (run_s && !zero_b_s) begin
      DataOutputB = hit_b_s ? WriteData : mem_q[ReadAddrB];
      BusyB       = busy_q[ReadAddrB];
    end else begin
      DataOutputB = {WIDTH{1'b0}};
      BusyB       = 1'b0;
    end
  end

  assign Ready        = ready_q;
  assign WriteDropped = dropped_q;

endmodule

// File: tb/tb_regfile_param.sv
// Randomized self-checking bench: four regfile_param builds share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_regfile_param;

  localparam int NDUT = 4;

  logic        clk;
  logic        rst;
  logic        write;
  logic        reserve;
  logic [5:0]  wa, ra, rda, rdb;
  logic [31:0] wd;

  logic [15:0] doa0, dob0, doa1, dob1, doa2, dob2;
  logic [31:0] doa3, dob3;
  logic [3:0]  bsa, bsb, rdy, drp;
  logic [31:0] oa [NDUT];
  logic [31:0] ob [NDUT];

  int          depth_p [NDUT] = '{16, 16, 16, 64};
  bit          zr_p    [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit          byp_p   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] mask_p  [NDUT] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};

  logic [31:0] m_mem   [NDUT][64];
  bit          m_busy  [NDUT][64];
  int          m_since [NDUT];
  bit          m_drop  [NDUT];

  int n_vec;
  int n_bad;
  int first_rdy [NDUT];

  regfile_param u_def (
    .clk(clk), .rst(rst), .write(write), .WriteAddress(wa[3:0]), .WriteData(wd[15:0]),
    .Reserve(reserve), .ReserveAddr(ra[3:0]), .ReadAddrA(rda[3:0]), .ReadAddrB(rdb[3:0]),
    .DataOutputA(doa0), .DataOutputB(dob0), .BusyA(bsa[0]), .BusyB(bsb[0]),
    .Ready(rdy[0]), .WriteDropped(drp[0]));

  regfile_param #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .write(write), .WriteAddress(wa[3:0]), .WriteData(wd[15:0]),
    .Reserve(reserve), .ReserveAddr(ra[3:0]), .ReadAddrA(rda[3:0]), .ReadAddrB(rdb[3:0]),
    .DataOutputA(doa1), .DataOutputB(dob1), .BusyA(bsa[1]), .BusyB(bsb[1]),
    .Ready(rdy[1]), .WriteDropped(drp[1]));

  regfile_param #(.ZERO_REG(1'b1)) u_zero (
    .clk(clk), .rst(rst), .write(write), .WriteAddress(wa[3:0]), .WriteData(wd[15:0]),
    .Reserve(reserve), .ReserveAddr(ra[3:0]), .ReadAddrA(rda[3:0]), .ReadAddrB(rdb[3:0]),
    .DataOutputA(doa2), .DataOutputB(dob2), .BusyA(bsa[2]), .BusyB(bsb[2]),
    .Ready(rdy[2]), .WriteDropped(drp[2]));

  regfile_param #(.WIDTH(32), .DEPTH(64)) u_big (
    .clk(clk), .rst(rst), .write(write), .WriteAddress(wa), .WriteData(wd),
    .Reserve(reserve), .ReserveAddr(ra), .ReadAddrA(rda), .ReadAddrB(rdb),
    .DataOutputA(doa3), .DataOutputB(dob3), .BusyA(bsa[3]), .BusyB(bsb[3]),
    .Ready(rdy[3]), .WriteDropped(drp[3]));

  always_comb begin
    oa[0] = {16'h0000, doa0};
    ob[0] = {16'h0000, dob0};
    oa[1] = {16'h0000, doa1};
    ob[1] = {16'h0000, dob1};
    oa[2] = {16'h0000, doa2};
    ob[2] = {16'h0000, dob2};
    oa[3] = doa3;
    ob[3] = dob3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_run(int i);
    return !rst && (m_since[i] >= depth_p[i]);
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [5:0] addr);
    int a;
    a = int'(addr) % depth_p[i];
    if (!m_run(i)) return 32'h0;
    if (zr_p[i] && a == 0) return 32'h0;
    if (byp_p[i] && write && a == int'(wa) % depth_p[i]) return wd & mask_p[i];
    return m_mem[i][a];
  endfunction

  function automatic logic [31:0] exp_busy(int i, logic [5:0] addr);
    int a;
    a = int'(addr) % depth_p[i];
    if (!m_run(i) || (zr_p[i] && a == 0)) return 32'h0;
    return {31'h0, m_busy[i][a]};
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("d%0d_doa", i), oa[i], exp_rd(i, rda));
      chk($sformatf("d%0d_dob", i), ob[i], exp_rd(i, rdb));
      chk($sformatf("d%0d_busya", i), {31'h0, bsa[i]}, exp_busy(i, rda));
      chk($sformatf("d%0d_busyb", i), {31'h0, bsb[i]}, exp_busy(i, rdb));
      chk($sformatf("d%0d_ready", i), {31'h0, rdy[i]}, {31'h0, m_run(i)});
      chk($sformatf("d%0d_drop", i), {31'h0, drp[i]}, {31'h0, (!rst && m_drop[i])});
    end
  endtask

  task automatic model_edge();
    int w, r;
    for (int i = 0; i < NDUT; i++) begin
      w = int'(wa) % depth_p[i];
      r = int'(ra) % depth_p[i];
      if (rst) begin
        m_since[i] = 0;
        m_drop[i]  = 1'b0;
      end else if (m_since[i] < depth_p[i]) begin
        m_mem[i][m_since[i]]  = 32'h0;
        m_busy[i][m_since[i]] = 1'b0;
        m_drop[i] = write | reserve;
        m_since[i]++;
      end else begin
        m_drop[i] = 1'b0;
        if (write && !(zr_p[i] && w == 0)) begin
          m_mem[i][w]  = wd & mask_p[i];
          m_busy[i][w] = 1'b0;
        end
        if (reserve && !(zr_p[i] && r == 0)) m_busy[i][r] = 1'b1;
      end
    end
  endtask

  task automatic tick_pre();
    #1;
    check_outputs();
  endtask

  task automatic tick_post();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic idle_inputs();
    write = 1'b0; reserve = 1'b0;
    wa = 6'd0; ra = 6'd0; rda = 6'd0; rdb = 6'd0; wd = 32'h0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < NDUT; i++) begin
      m_since[i] = 0;
      m_drop[i]  = 1'b0;
      first_rdy[i] = -1;
      for (int j = 0; j < 64; j++) begin
        m_mem[i][j]  = 32'h0;
        m_busy[i][j] = 1'b0;
      end
    end
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) tick();

    // First clear, interrupted at step 20 of the 64-deep build.
    rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    tick_pre();
    chk("rst_mid_ready", {31'h0, rdy[3]}, 32'h0);
    chk("rst_mid_drop", {31'h0, drp[3]}, 32'h0);
    tick_post();
    tick();
    rst = 1'b0;

    // Count edges to Ready; a stray write at clear step 3 must be dropped.
    for (int n = 0; n < 200 && first_rdy[3] < 0; n++) begin
      write = (n == 3);
      wa = 6'd5;
      wd = 32'h0000_2025;
      tick();
      if (n == 3) begin
        chk("clr_drop_d0", {31'h0, drp[0]}, 32'h1);
        chk("clr_drop_d3", {31'h0, drp[3]}, 32'h1);
      end
      for (int i = 0; i < NDUT; i++)
        if (rdy[i] && first_rdy[i] < 0) first_rdy[i] = n + 1;
    end
    idle_inputs();
    chk("rdy_lat16", 32'(first_rdy[0]), 32'd16);
    chk("rdy_lat64", 32'(first_rdy[3]), 32'd64);

    for (int r = 0; r < 16; r++) begin
      rda = 6'(r);
      rdb = 6'(r);
      tick_pre();
      chk("cleared_data", oa[0], 32'h0);
      chk("cleared_busy", {31'h0, bsa[0]}, 32'h0);
      tick_post();
    end

    // Same-cycle bypass vs. registered read.
    write = 1'b1; wa = 6'd5; wd = 32'h0000_2025; rda = 6'd5;
    tick_pre();
    chk("byp_same", oa[0], 32'h0000_2025);
    chk("nobyp_same", oa[1], 32'h0);
    tick_post();
    write = 1'b0;
    tick_pre();
    chk("byp_next", oa[0], 32'h0000_2025);
    chk("nobyp_next", oa[1], 32'h0000_2025);
    tick_post();

    // Reserve / write-clears-busy / reserve-wins.
    reserve = 1'b1; ra = 6'd3; rdb = 6'd3;
    tick();
    reserve = 1'b0;
    chk("resv_busy", {31'h0, bsb[0]}, 32'h1);
    write = 1'b1; wa = 6'd3; wd = 32'h0000_5678;
    tick();
    write = 1'b0;
    chk("wr_clr_busy", {31'h0, bsb[0]}, 32'h0);
    chk("wr_data", ob[0], 32'h0000_5678);
    write = 1'b1; reserve = 1'b1; wd = 32'h0000_5678;
    tick();
    write = 1'b0; reserve = 1'b0;
    chk("both_busy", {31'h0, bsb[0]}, 32'h1);
    chk("both_data", ob[0], 32'h0000_5678);

    // Hardwired zero register.
    write = 1'b1; reserve = 1'b1; wa = 6'd0; ra = 6'd0; wd = 32'h0000_FFFF; rda = 6'd0;
    tick_pre();
    chk("zr_same", oa[2], 32'h0);
    tick_post();
    idle_inputs();
    tick_pre();
    chk("zr_after", oa[2], 32'h0);
    chk("zr_busy", {31'h0, bsa[2]}, 32'h0);
    chk("zr_nodrop", {31'h0, drp[2]}, 32'h0);
    chk("nz_reg0", oa[0], 32'h0000_FFFF);
    tick_post();

    // Random sweep, with one mid-run reset.
    for (int k = 0; k < 3000; k++) begin
      rst     = (k == 1500);
      write   = ($urandom_range(0, 1) == 1);
      reserve = ($urandom_range(0, 3) == 0);
      wa      = 6'($urandom_range(0, 63));
      ra      = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      rda     = ($urandom_range(0, 1) == 1) ? wa : 6'($urandom_range(0, 63));
      rdb     = ($urandom_range(0, 2) == 0) ? ra : 6'($urandom_range(0, 63));
      wd      = $urandom;
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
